// File: rtl/br_pkg.sv
// Shared constants for the EX-stage branch resolver: condition codes, compare-flag
// bit positions, FSM state encoding and the taken decision.
package br_pkg;

  localparam logic [2:0] COND_EQ     = 3'd0;
  localparam logic [2:0] COND_NE     = 3'd1;
  localparam logic [2:0] COND_LT     = 3'd2;
  localparam logic [2:0] COND_GT     = 3'd3;
  localparam logic [2:0] COND_EZ     = 3'd4;
  localparam logic [2:0] COND_ALWAYS = 3'd5;
  localparam logic [2:0] COND_LE     = 3'd6;
  localparam logic [2:0] COND_GE     = 3'd7;

  localparam int CMP_EQ = 4;
  localparam int CMP_NE = 3;
  localparam int CMP_LT = 2;
  localparam int CMP_GT = 1;
  localparam int CMP_Z  = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } br_state_e;

  function automatic logic cond_taken(input logic [2:0] cond, input logic [4:0] cmp);
    logic t;
    t = 1'b0;
    case (cond)
      COND_EQ:     t = cmp[CMP_EQ];
      COND_NE:     t = cmp[CMP_NE];
      COND_LT:     t = cmp[CMP_LT];
      COND_GT:     t = cmp[CMP_GT];
      COND_EZ:     t = cmp[CMP_Z];
      COND_ALWAYS: t = 1'b1;
      COND_LE:     t = cmp[CMP_LT] | cmp[CMP_EQ];
      COND_GE:     t = cmp[CMP_GT] | cmp[CMP_EQ];
      default:     t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a same-cycle increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Resolves the EX-stage branch, issues a PC redirect to fetch with valid/ready and
// holds flush for a fixed window afterwards; keeps saturating debug counters.
//
// state    | meaning
// IDLE     | ready for a branch; no flush
// REDIRECT | target presented to fetch, waiting for redirect_ready
// FLUSH    | redirect accepted; fcnt counts down the remaining flush cycles
module branch_resolve
  import br_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int PC_INC       = 4,
  parameter int OFF_SHIFT    = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [4:0]        compare_in,
  input  logic [DATA_W-1:0] br_pc,
  input  logic [DATA_W-1:0] br_offset,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam int FCNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  br_state_e         state, state_nxt;
  logic [FCNT_W-1:0] fcnt, fcnt_nxt;
  logic              accept;
  logic              taken;
  logic [DATA_W-1:0] target;

  assign br_ready = (state == IDLE);
  assign accept   = br_valid & br_ready;
  assign taken    = cond_taken(br_cond, compare_in);
  // Modulo-2^DATA_W add; wrap-around is intentional and silent.
  assign target   = br_pc + DATA_W'(PC_INC) + (br_offset << OFF_SHIFT);

  assign redirect_valid = (state == REDIRECT);
  assign flush          = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fcnt        <= '0;
      redirect_pc <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      if (accept && taken) begin
        redirect_pc <= target;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    case (state)
      IDLE: begin
        if (accept && taken) begin
          state_nxt = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = FLUSH;
            fcnt_nxt  = FCNT_W'(FLUSH_CYCLES);
          end
        end
      end
      FLUSH: begin
        // Terminal count is 1: the flush window ends on the cycle fcnt reads 1.
        if (fcnt == FCNT_W'(1)) begin
          state_nxt = IDLE;
          fcnt_nxt  = '0;
        end else begin
          fcnt_nxt = fcnt - FCNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        fcnt_nxt  = '0;
      end
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .clr   (cnt_clr),
    .count (branch_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept & taken),
    .clr   (cnt_clr),
    .count (taken_cnt)
  );

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench: a default branch_resolve and a narrow-counter, zero-flush copy
// share one stimulus stream; expected values are hand-computed constants.
module tb_branch_resolve;

  logic        clk;
  logic        rst;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [4:0]  compare_in;
  logic [31:0] br_pc;
  logic [31:0] br_offset;
  logic        redirect_ready;
  logic        cnt_clr;

  logic        br_ready, redirect_valid, flush;
  logic [31:0] redirect_pc;
  logic [15:0] branch_cnt, taken_cnt;

  logic        br_ready4, redirect_valid4, flush4;
  logic [31:0] redirect_pc4;
  logic [3:0]  branch_cnt4, taken_cnt4;

  int vectors;
  int miscompares;
  int exp_taken_total;

  logic [4:0] cmp_tbl [4];
  logic [7:0] exp_tbl [4];

  branch_resolve dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready),
    .br_cond(br_cond), .compare_in(compare_in), .br_pc(br_pc), .br_offset(br_offset),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .flush(flush), .cnt_clr(cnt_clr),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  branch_resolve #(.CNT_W(4), .FLUSH_CYCLES(0)) dut4 (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready4),
    .br_cond(br_cond), .compare_in(compare_in), .br_pc(br_pc), .br_offset(br_offset),
    .redirect_valid(redirect_valid4), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc4), .flush(flush4), .cnt_clr(cnt_clr),
    .branch_cnt(branch_cnt4), .taken_cnt(taken_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    br_valid = 1'b0;
    br_cond = 3'd0;
    compare_in = 5'd0;
    br_pc = 32'd0;
    br_offset = 32'd0;
    redirect_ready = 1'b0;
    cnt_clr = 1'b0;
    cmp_tbl[0] = 5'b10001; exp_tbl[0] = 8'hF1;
    cmp_tbl[1] = 5'b01100; exp_tbl[1] = 8'h66;
    cmp_tbl[2] = 5'b01010; exp_tbl[2] = 8'hAA;
    cmp_tbl[3] = 5'b00001; exp_tbl[3] = 8'h30;

    // Reset
    tick();
    tick();
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_branch_cnt", {16'd0, branch_cnt}, 32'd0);
    chk("rst_taken_cnt", {16'd0, taken_cnt}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_br_ready", {31'd0, br_ready}, 32'd1);

    // EQ taken, fetch ready immediately
    br_valid = 1'b1; br_cond = 3'b000; compare_in = 5'b10001;
    br_pc = 32'h100; br_offset = 32'd3; redirect_ready = 1'b1;
    tick();
    br_valid = 1'b0;
    chk("eq_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("eq_redirect_pc", redirect_pc, 32'h110);
    chk("eq_flush_c1", {31'd0, flush}, 32'd1);
    chk("eq_ready_c1", {31'd0, br_ready}, 32'd0);
    chk("eq_branch_cnt", {16'd0, branch_cnt}, 32'd1);
    chk("eq_taken_cnt", {16'd0, taken_cnt}, 32'd1);
    chk("eq_z_flush_c1", {31'd0, flush4}, 32'd1);
    tick();
    chk("eq_flush_c2", {31'd0, flush}, 32'd1);
    chk("eq_rv_c2", {31'd0, redirect_valid}, 32'd0);
    chk("eq_ready_c2", {31'd0, br_ready}, 32'd0);
    chk("eq_z_flush_c2", {31'd0, flush4}, 32'd0);
    tick();
    chk("eq_flush_c3", {31'd0, flush}, 32'd1);
    chk("eq_ready_c3", {31'd0, br_ready}, 32'd0);
    tick();
    chk("eq_flush_c4", {31'd0, flush}, 32'd0);
    chk("eq_ready_c4", {31'd0, br_ready}, 32'd1);

    // NE not taken, from cleared counters
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_branch_cnt", {16'd0, branch_cnt}, 32'd0);
    br_valid = 1'b1; br_cond = 3'b001; compare_in = 5'b10000;
    tick();
    br_valid = 1'b0;
    chk("ne_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("ne_flush", {31'd0, flush}, 32'd0);
    chk("ne_ready", {31'd0, br_ready}, 32'd1);
    chk("ne_branch_cnt", {16'd0, branch_cnt}, 32'd1);
    chk("ne_taken_cnt", {16'd0, taken_cnt}, 32'd0);

    // Backpressure: GT taken, negative offset, fetch stalls 4 cycles
    br_valid = 1'b1; br_cond = 3'b011; compare_in = 5'b01010;
    br_pc = 32'h20; br_offset = 32'hFFFF_FFFF; redirect_ready = 1'b0;
    tick();
    br_valid = 1'b0;
    br_pc = 32'hDEAD_0000;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_rv_%0d", i), {31'd0, redirect_valid}, 32'd1);
      chk($sformatf("bp_pc_%0d", i), redirect_pc, 32'h20);
      chk($sformatf("bp_flush_%0d", i), {31'd0, flush}, 32'd1);
      if (i < 3) tick();
    end
    redirect_ready = 1'b1;
    tick();
    chk("bp_rv_done", {31'd0, redirect_valid}, 32'd0);
    chk("bp_flush_a1", {31'd0, flush}, 32'd1);
    tick();
    chk("bp_flush_a2", {31'd0, flush}, 32'd1);
    tick();
    chk("bp_flush_a3", {31'd0, flush}, 32'd0);
    chk("bp_ready_a3", {31'd0, br_ready}, 32'd1);

    // Sweep all 8 codes against 4 flag patterns
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    br_pc = 32'h0; br_offset = 32'h0;
    exp_taken_total = 0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 8; k++) begin
        br_valid = 1'b1; br_cond = 3'(k); compare_in = cmp_tbl[c];
        tick();
        br_valid = 1'b0;
        chk($sformatf("sweep_c%0d_k%0d", c, k), {31'd0, redirect_valid}, {31'd0, exp_tbl[c][k]});
        if (exp_tbl[c][k]) begin
          exp_taken_total++;
          tick(); tick(); tick();
        end
      end
    end
    chk("sweep_branch_cnt", {16'd0, branch_cnt}, 32'd32);
    chk("sweep_taken_cnt", {16'd0, taken_cnt}, 32'd15);
    chk("sweep_taken_model", 32'(exp_taken_total), {16'd0, taken_cnt});
    chk("sweep_sat_branch4", {28'd0, branch_cnt4}, 32'd15);
    chk("sweep_sat_taken4", {28'd0, taken_cnt4}, 32'd15);

    // Target wrap-around
    br_valid = 1'b1; br_cond = 3'b101; br_pc = 32'hFFFF_FFF8; br_offset = 32'd1;
    tick();
    br_valid = 1'b0;
    chk("wrap_redirect_pc", redirect_pc, 32'h0000_0000);
    chk("wrap_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    tick(); tick(); tick();

    // Saturation with a 4-bit counter, then clear colliding with an accept
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    br_valid = 1'b1; br_cond = 3'b000; compare_in = 5'b00001;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_branch4", {28'd0, branch_cnt4}, 32'd15);
    chk("sat_branch16", {16'd0, branch_cnt}, 32'd20);
    chk("sat_taken16", {16'd0, taken_cnt}, 32'd0);
    br_cond = 3'b101; cnt_clr = 1'b1;
    tick();
    br_valid = 1'b0; cnt_clr = 1'b0;
    chk("clr_pri_branch4", {28'd0, branch_cnt4}, 32'd0);
    chk("clr_pri_branch16", {16'd0, branch_cnt}, 32'd0);
    chk("clr_pri_taken16", {16'd0, taken_cnt}, 32'd0);
    chk("clr_pri_redirect", {31'd0, redirect_valid}, 32'd1);
    tick(); tick(); tick();

    // Reset while flushing
    br_valid = 1'b1; br_cond = 3'b101; br_pc = 32'h400; br_offset = 32'd8;
    tick();
    br_valid = 1'b0;
    tick();
    chk("rstmid_in_flush", {31'd0, flush}, 32'd1);
    rst = 1'b1;
    #2;
    chk("rstmid_async_flush", {31'd0, flush}, 32'd0);
    chk("rstmid_async_rv", {31'd0, redirect_valid}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rstmid_flush", {31'd0, flush}, 32'd0);
    chk("rstmid_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rstmid_ready", {31'd0, br_ready}, 32'd1);
    chk("rstmid_pc", redirect_pc, 32'd0);
    chk("rstmid_branch_cnt", {16'd0, branch_cnt}, 32'd0);
    chk("rstmid_taken_cnt", {16'd0, taken_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
